hamming_secded_dec_pipe: RTL and testbench

//  Parametrised, pipelined SECDED (extended Hamming) decoder; successor to the fixed 16-bit combinational decoder.

---
 rtl/hamming_secded_dec_pipe.sv | 191 +++++++++++++++++++
 tb/tb_hamming_secded_dec_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_dec_pipe.sv
// Pipelined SECDED (extended Hamming) decoder: corrects single-bit errors, flags double-bit errors.
// Latency: 2 cycles from acceptance to out_valid_o; one word per cycle sustained.
// Backpressure: valid/ready; the output stalls while !out_ready_i, stage 1 fills behind it (capacity 2 words).
//
// Ports:
//   clk_i, rst_n_i             rising-edge clock, synchronous active-low reset
//   in_valid_i/in_ready_o      codeword handshake; in_cw_i[i-1] = Hamming position i, in_cw_i[N-1] = overall parity
//   out_valid_o/out_ready_i    result handshake; out_data_o corrected data
//   err_single_o/err_double_o  single error corrected / uncorrectable error (qualified by out_valid_o)
//   err_pos_o                  corrected position 1..HN; 0 for overall-parity bit, clean or uncorrectable word
//   cnt_clr_i, cnt_single_o, cnt_double_o  saturating delivered-error counters
//
// Optional feature: define HAMDEC_ERRCNT_EN to build the error counters. Without it the counters
// read as zero and cnt_clr_i has no effect; the decode path is identical either way.

module hamming_secded_dec_pipe #(
    parameter int DATA_W = 16,
    parameter int P      = 5,
    parameter int CNT_W  = 16,
    localparam int N     = DATA_W + P + 1,
    localparam int HN    = DATA_W + P,
    localparam int PW    = $clog2(N)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [N-1:0]      in_cw_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              err_single_o,
    output logic              err_double_o,
    output logic [PW-1:0]     err_pos_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  cnt_single_o,
    output logic [CNT_W-1:0]  cnt_double_o
);

    // P must be the minimal number of check bits for DATA_W.
    if (DATA_W < 1 || DATA_W > 57) begin : g_bad_data_w
        $error("hamming_secded_dec_pipe: DATA_W must be in 1..57");
    end
    if (!((2 ** P >= N) && (2 ** (P - 1) < HN))) begin : g_bad_p
        $error("hamming_secded_dec_pipe: P is not the smallest value with 2**P >= DATA_W+P+1");
    end

    localparam logic [P-1:0] HN_P = P'(HN);

    // Hamming position (1-based) carrying data bit j: the j-th position that is not a power of two.
    function automatic int dpos(input int j);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int i = 1; i <= HN; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == j) res = i;
                cnt++;
            end
        end
        return res;
    endfunction

    // ---------------- stage 1: syndrome and overall parity ----------------
    logic              s1_valid_q;
    logic [P-1:0]      s1_syn_q;
    logic              s1_op_q;
    logic [HN-1:0]     s1_cw_q;

    logic [P-1:0]      syn_d;
    logic              op_d;
    logic              s1_en;
    logic              s2_adv;

    always_comb begin
        syn_d = '0;
        for (int i = 1; i <= HN; i++) begin
            for (int k = 0; k < P; k++) begin
                if (((i >> k) & 1) != 0) syn_d[k] = syn_d[k] ^ in_cw_i[i-1];
            end
        end
        op_d = ^in_cw_i;
    end

    // Output register frees up when empty or being consumed; stage 1 loads when it is empty
    // or its word moves on, so bubbles collapse and the pipe holds at most two words.
    assign s2_adv     = !out_valid_o || out_ready_i;
    assign s1_en      = !s1_valid_q || s2_adv;
    assign in_ready_o = rst_n_i && s1_en;

    // ---------------- stage 2: classify and correct ----------------
    logic              syn_nz;
    logic              in_range;
    logic              flip;
    logic              single_d;
    logic              double_d;
    logic [PW-1:0]     pos_d;
    logic [HN-1:0]     corr_cw;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        syn_nz   = |s1_syn_q;
        in_range = (s1_syn_q <= HN_P);
        // op=1 means an odd number of flips; a syndrome pointing past HN cannot be a single error.
        flip     = s1_op_q && syn_nz && in_range;
        single_d = s1_op_q && (!syn_nz || in_range);
        double_d = syn_nz && (!s1_op_q || !in_range);
        pos_d    = flip ? PW'(s1_syn_q) : '0;
        corr_cw  = s1_cw_q;
        for (int i = 1; i <= HN; i++) begin
            if (flip && (int'(s1_syn_q) == i)) corr_cw[i-1] = !s1_cw_q[i-1];
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        assign data_d[j] = corr_cw[dpos(j) - 1];
    end

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              err_single_q;
    logic              err_double_q;
    logic [PW-1:0]     err_pos_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_valid_q   <= 1'b0;
            s1_syn_q     <= '0;
            s1_op_q      <= 1'b0;
            s1_cw_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            err_single_q <= 1'b0;
            err_double_q <= 1'b0;
            err_pos_q    <= '0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= in_valid_i;
                s1_syn_q   <= syn_d;
                s1_op_q    <= op_d;
                s1_cw_q    <= in_cw_i[HN-1:0];
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                // Bubbles leave the last result in place; it is not qualified by out_valid.
                if (s1_valid_q) begin
                    out_data_q   <= data_d;
                    err_single_q <= single_d;
                    err_double_q <= double_d;
                    err_pos_q    <= pos_d;
                end
            end
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign err_single_o = err_single_q;
    assign err_double_o = err_double_q;
    assign err_pos_o    = err_pos_q;

    // ---------------- optional error counters ----------------
`ifdef HAMDEC_ERRCNT_EN
    logic [CNT_W-1:0] cnt_single_q;
    logic [CNT_W-1:0] cnt_double_q;
    logic             deliver;

    assign deliver = out_valid_q && out_ready_i;

    // Clear takes priority over an increment in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || cnt_clr_i) begin
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else begin
            if (deliver && err_single_q && (cnt_single_q != '1)) cnt_single_q <= cnt_single_q + CNT_W'(1);
            if (deliver && err_double_q && (cnt_double_q != '1)) cnt_double_q <= cnt_double_q + CNT_W'(1);
        end
    end

    assign cnt_single_o = cnt_single_q;
    assign cnt_double_o = cnt_double_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign cnt_single_o   = '0;
    assign cnt_double_o   = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// Scoreboard bench for hamming_secded_dec_pipe (DATA_W=16, P=5, CNT_W=4).
// Expected results come from an encoder/error-injection model; a monitor pops and compares.
// Inputs change 1 time unit after the rising edge; handshakes and outputs are sampled on the falling edge.

module tb_hamming_secded_dec_pipe;

    localparam int DW = 16;
    localparam int PB = 5;
    localparam int CW = 4;
    localparam int N  = DW + PB + 1;
    localparam int HN = DW + PB;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_cw     = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          err_single;
    logic          err_double;
    logic [4:0]    err_pos;
    logic          cnt_clr   = 1'b0;
    logic [CW-1:0] cnt_single;
    logic [CW-1:0] cnt_double;

    always #5 clk = ~clk;

    hamming_secded_dec_pipe #(.DATA_W(DW), .P(PB), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_cw_i      (in_cw),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .err_single_o (err_single),
        .err_double_o (err_double),
        .err_pos_o    (err_pos),
        .cnt_clr_i    (cnt_clr),
        .cnt_single_o (cnt_single),
        .cnt_double_o (cnt_double)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          s;
        logic          d;
        logic [4:0]    pos;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t          q[$];
    exp_t          cur_exp;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    logic [CW-1:0] m_cs  = '0;
    logic [CW-1:0] m_cd  = '0;
    bit            rand_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] encode(input logic [DW-1:0] d);
        logic [N-1:0] cw;
        int j;
        logic par;
        cw = '0;
        j  = 0;
        for (int i = 1; i <= HN; i++) begin
            if ($countones(i) != 1) begin
                cw[i-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < PB; k++) begin
            par = 1'b0;
            for (int i = 1; i <= HN; i++) begin
                if (((i / (2 ** k)) % 2) == 1) par = par ^ cw[i-1];
            end
            cw[(2 ** k) - 1] = par;
        end
        cw[N-1] = ^cw[HN-1:0];
        return cw;
    endfunction

    function automatic logic [DW-1:0] extract(input logic [N-1:0] cw);
        logic [DW-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 1; i <= HN; i++) begin
            if ($countones(i) != 1) begin
                d[j] = cw[i-1];
                j++;
            end
        end
        return d;
    endfunction

    function automatic exp_t mkexp(input logic [DW-1:0] d, input logic s, input logic db,
                                   input logic [4:0] pos, input bit lat);
        exp_t e;
        e.data = d;
        e.s    = s;
        e.d    = db;
        e.pos  = pos;
        e.acc  = 0;
        e.lat  = lat;
        return e;
    endfunction

    // ---------------- acceptance watcher: push expectation ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && in_valid && in_ready) begin
            e     = cur_exp;
            e.acc = cyc;
            q.push_back(e);
        end
    end

    // ---------------- monitor: pop and compare ----------------
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        have = 1'b0;
        chk("cnt_single", cnt_single, m_cs);
        chk("cnt_double", cnt_double, m_cd);
        if (!rst_n) begin
            q.delete();
            m_cs = '0;
            m_cd = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", out_valid, 1'b0);
                end else begin
                    e    = q.pop_front();
                    have = 1'b1;
                    chk("word{data,single,double,pos}",
                        {out_data, err_single, err_double, err_pos}, {e.data, e.s, e.d, e.pos});
                    if (e.lat) chk("latency", cyc - e.acc, 2);
                end
            end
`ifdef HAMDEC_ERRCNT_EN
            if (cnt_clr) begin
                m_cs = '0;
                m_cd = '0;
            end else if (have) begin
                if (e.s && m_cs != '1) m_cs = m_cs + 1'b1;
                if (e.d && m_cd != '1) m_cd = m_cd + 1'b1;
            end
`endif
        end
    end

    // ---------------- random backpressure ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic send(input logic [N-1:0] cw, input exp_t e);
        int b;
        b        = 0;
        in_cw    = cw;
        cur_exp  = e;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input int nf_min, input int nf_max, input bit lat);
        logic [DW-1:0] d;
        logic [N-1:0]  cw;
        int nf, p1, p2;
        exp_t e;
        d  = DW'($urandom);
        cw = encode(d);
        nf = $urandom_range(nf_min, nf_max);
        p1 = $urandom_range(0, N - 1);
        p2 = (p1 + $urandom_range(1, N - 1)) % N;
        e  = mkexp(d, 1'b0, 1'b0, 5'd0, lat);
        if (nf == 1) begin
            cw[p1] = ~cw[p1];
            e.s    = 1'b1;
            e.pos  = (p1 == N - 1) ? 5'd0 : 5'(p1 + 1);
        end else if (nf == 2) begin
            cw[p1] = ~cw[p1];
            cw[p2] = ~cw[p2];
            e.d    = 1'b1;
            e.data = extract(cw);
        end
        send(cw, e);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (q.size() != 0 && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    endtask

    task automatic clr_pulse();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_single_after_clr", cnt_single, 0);
        chk("cnt_double_after_clr", cnt_double, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"},   in_ready,   1'b0);
        chk({tag, "_out_valid"},  out_valid,  1'b0);
        chk({tag, "_out_data"},   out_data,   0);
        chk({tag, "_err_single"}, err_single, 1'b0);
        chk({tag, "_err_double"}, err_double, 1'b0);
        chk({tag, "_err_pos"},    err_pos,    0);
        chk({tag, "_cnt_single"}, cnt_single, 0);
        chk({tag, "_cnt_double"}, cnt_double, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [CW-1:0] sat_exp;
`ifdef HAMDEC_ERRCNT_EN
        sat_exp = 4'hF;
`else
        sat_exp = 4'h0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed codewords, back to back, latency checked.
        send(22'h000000, mkexp(16'h0000, 1'b0, 1'b0, 5'd0, 1'b1));
        send(22'h000004, mkexp(16'h0000, 1'b1, 1'b0, 5'd3, 1'b1));
        send(22'h000006, mkexp(16'h0001, 1'b0, 1'b1, 5'd0, 1'b1));
        send(22'h200000, mkexp(16'h0000, 1'b1, 1'b0, 5'd0, 1'b1));
        drain();
        @(posedge clk);
        #1;

        // Capacity: with the output stalled only two words get in.
        out_ready = 1'b0;
        send_rand(0, 1, 1'b0);
        send_rand(0, 1, 1'b0);
        begin
            logic [DW-1:0] d;
            int b;
            d        = DW'($urandom);
            in_cw    = encode(d);
            cur_exp  = mkexp(d, 1'b0, 1'b0, 5'd0, 1'b0);
            in_valid = 1'b1;
            repeat (4) begin
                @(negedge clk);
                chk("in_ready_when_full", in_ready, 1'b0);
                chk("out_valid_when_full", out_valid, 1'b1);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            b = 0;
            @(negedge clk);
            while (!in_ready && b < 20) begin
                @(negedge clk);
                b++;
            end
            if (!in_ready) chk("third_word_timeout", in_ready, 1'b1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        drain();
        @(posedge clk);
        #1;

        // Random words with random gaps and random backpressure.
        rand_bp = 1'b1;
        for (int n = 0; n < 150; n++) begin
            send_rand(0, 2, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        @(posedge clk);
        #1;

        // Counter saturation and clear.
        clr_pulse();
        for (int n = 0; n < 20; n++) send_rand(1, 1, 1'b1);
        drain();
        @(negedge clk);
        chk("cnt_single_saturated", cnt_single, sat_exp);
        chk("cnt_double_zero", cnt_double, 0);
        @(posedge clk);
        #1;
        clr_pulse();

        // Reset in the middle of a stream: in-flight words are dropped.
        for (int n = 0; n < 3; n++) send_rand(1, 2, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_state("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_midreset", in_ready, 1'b1);
        repeat (8) @(negedge clk);
        chk("no_stale_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        for (int n = 0; n < 5; n++) send_rand(0, 2, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
